// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the round-robin memory-port arbiter.
// The optional bus timeout is enabled with ARB_TIMEOUT_EN.
package bus_arbiter_pkg;

    localparam int unsigned XLEN_DEF        = 32;
    localparam int unsigned NUM_CH_DEF      = 2;
    localparam int unsigned TIMEOUT_CYC_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Index width for a channel count; never below one bit.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request bit starting at ptr_i,
// wrapping modulo N. Returns one-hot grant, binary index and a found flag.
module bus_arbiter_rr_picker #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    logic [PW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = PW'((32'(ptr_i) + i) % N);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = cand;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/bus_arbiter.sv
// N-channel round-robin arbiter onto a single wait-state memory bus.
// Define ARB_TIMEOUT_EN to abort a BUSY phase after TIMEOUT_CYC cycles.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CH      = NUM_CH_DEF,
    parameter int unsigned XLEN        = XLEN_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CH-1:0]             ch_req_i,
    input  logic [NUM_CH-1:0]             ch_we_i,
    input  logic [NUM_CH*XLEN-1:0]        ch_addr_i,
    input  logic [NUM_CH*XLEN-1:0]        ch_wdata_i,
    input  logic [NUM_CH*(XLEN/8)-1:0]    ch_be_i,
    output logic [NUM_CH-1:0]             ch_gnt_o,
    output logic [NUM_CH-1:0]             ch_rvalid_o,
    output logic [XLEN-1:0]               ch_rdata_o,
    output logic [NUM_CH-1:0]             ch_err_o,
    output logic [NUM_CH-1:0]             ch_stall_o,
    output logic                          m_req_o,
    output logic                          m_we_o,
    output logic [XLEN-1:0]               m_addr_o,
    output logic [XLEN-1:0]               m_wdata_o,
    output logic [XLEN/8-1:0]             m_be_o,
    input  logic                          m_ready_i,
    input  logic [XLEN-1:0]               m_rdata_i
);

    localparam int unsigned CH_W = ch_w(NUM_CH);
    localparam int unsigned BE_W = XLEN / 8;

    if (NUM_CH < 2 || NUM_CH > 8 || XLEN < 8 || (XLEN % 8) != 0 || TIMEOUT_CYC < 1)
    begin : g_bad_param
        $error("bus_arbiter: parameter out of range");
    end

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BE_W-1:0] be;
    } bus_cmd_t;

    // Per-channel view of the packed request fields.
    bus_cmd_t cmd_a [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign cmd_a[c] = '{we:    ch_we_i[c],
                            addr:  ch_addr_i[c*XLEN +: XLEN],
                            wdata: ch_wdata_i[c*XLEN +: XLEN],
                            be:    ch_be_i[c*BE_W +: BE_W]};
    end

    logic [NUM_CH-1:0] pick_gnt;
    logic [CH_W-1:0]   pick_idx;
    logic              pick_valid;

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [NUM_CH-1:0] rvalid_q, rvalid_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              m_req_q, m_req_d;
    bus_cmd_t          cmd_q, cmd_d;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [NUM_CH-1:0] err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    bus_arbiter_rr_picker #(
        .N  (NUM_CH),
        .PW (CH_W)
    ) u_picker (
        .req_i   (ch_req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        gnt_d    = gnt_q;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        m_req_d  = m_req_q;
        cmd_d    = cmd_q;
`ifdef ARB_TIMEOUT_EN
        err_d    = '0;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    cmd_d   = cmd_a[pick_idx];
                    gnt_d   = pick_gnt;
                    sel_d   = pick_idx;
                    ptr_d   = (pick_idx == CH_W'(NUM_CH - 1)) ? '0 : pick_idx + CH_W'(1);
                    m_req_d = 1'b1;
                    state_d = ST_BUSY;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUSY: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (m_ready_i) begin
                    rdata_d         = m_rdata_i;
                    rvalid_d[sel_q] = 1'b1;
                    m_req_d         = 1'b0;
                    state_d         = ST_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    rdata_d         = '0;
                    rvalid_d[sel_q] = 1'b1;
                    err_d[sel_q]    = 1'b1;
                    m_req_d         = 1'b0;
                    state_d         = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                // The requester still holds its request this cycle; do not re-arbitrate.
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            sel_q    <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            m_req_q  <= 1'b0;
            cmd_q    <= '0;
`ifdef ARB_TIMEOUT_EN
            err_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            m_req_q  <= m_req_d;
            cmd_q    <= cmd_d;
`ifdef ARB_TIMEOUT_EN
            err_q    <= err_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign ch_gnt_o    = gnt_q;
    assign ch_rvalid_o = rvalid_q;
    assign ch_rdata_o  = rdata_q;
    assign m_req_o     = m_req_q;
    assign m_we_o      = cmd_q.we;
    assign m_addr_o    = cmd_q.addr;
    assign m_wdata_o   = cmd_q.wdata;
    assign m_be_o      = cmd_q.be;

    // Stall is forced low while in reset so every output reads zero.
    assign ch_stall_o  = rst_i ? '0 : (ch_req_i & ~rvalid_q);

`ifdef ARB_TIMEOUT_EN
    assign ch_err_o    = err_q;
`else
    assign ch_err_o    = '0;
`endif

endmodule
